// File: rtl/digit_requester_pkg.sv
// Shared UART digit protocol: request byte, digit range and requester state encoding.
package digit_requester_pkg;

  localparam logic [7:0] REQUEST_BYTE = 8'hCC;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    FINISH    = 2'd3
  } state_t;

  // A response is a digit only when the high nibble is clear and the low nibble is 0..9.
  function automatic logic is_digit(input logic [7:0] b);
    return (b[7:4] == 4'd0) && (b[3:0] <= DIGIT_MAX);
  endfunction

endpackage

// File: rtl/digit_requester.sv
// Sends REQUEST_BYTE over UART and waits for a one-byte digit reply, retrying on timeout.
// tx_send two cycles after start (waits while tx_busy); done two cycles after the reply's rx_ready rise.
module digit_requester
  import digit_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int MAX_RETRIES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       busy,
  output logic       done,
  output logic [3:0] digit,
  output logic       err_timeout,
  output logic       err_invalid,
  output logic [1:0] retry_cnt
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             rx_ready_prev;
  logic             byte_evt;
  logic             timed_out;
  logic             can_retry;

  logic do_accept;
  logic do_send;
  logic do_digit;
  logic do_invalid;
  logic do_retry;
  logic do_timeout;
  logic do_finish;
  logic cnt_inc;

  assign byte_evt  = rx_ready & ~rx_ready_prev;
  assign timed_out = (cnt == CNT_LAST);
  assign can_retry = ({30'd0, retry_cnt} < 32'(MAX_RETRIES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:      state_nxt = start ? SEND : IDLE;
      SEND:      state_nxt = tx_busy ? SEND : WAIT_RESP;
      WAIT_RESP: begin
        // A reply landing on the timeout cycle still counts as a reply.
        if (byte_evt) begin
          state_nxt = FINISH;
        end else if (timed_out) begin
          state_nxt = can_retry ? SEND : FINISH;
        end else begin
          state_nxt = WAIT_RESP;
        end
      end
      FINISH:    state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_accept  = 1'b0;
    do_send    = 1'b0;
    do_digit   = 1'b0;
    do_invalid = 1'b0;
    do_retry   = 1'b0;
    do_timeout = 1'b0;
    do_finish  = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE:      do_accept = start;
      SEND:      do_send   = ~tx_busy;
      WAIT_RESP: begin
        if (byte_evt) begin
          do_digit   = is_digit(rx_data);
          do_invalid = ~is_digit(rx_data);
        end else if (timed_out) begin
          do_retry   = can_retry;
          do_timeout = ~can_retry;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      FINISH:    do_finish = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data       <= 8'h00;
      tx_send       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      digit         <= 4'd0;
      err_timeout   <= 1'b0;
      err_invalid   <= 1'b0;
      retry_cnt     <= 2'd0;
      cnt           <= '0;
      rx_ready_prev <= 1'b0;
    end else begin
      rx_ready_prev <= rx_ready;
      tx_send       <= do_send;
      done          <= do_finish;
      if (do_accept) begin
        busy        <= 1'b1;
        err_timeout <= 1'b0;
        err_invalid <= 1'b0;
        retry_cnt   <= 2'd0;
      end
      if (do_send) begin
        tx_data <= REQUEST_BYTE;
        cnt     <= '0;
      end else if (cnt_inc && (cnt != CNT_LAST)) begin
        cnt <= cnt + 1'b1;
      end
      if (do_digit) begin
        digit <= rx_data[3:0];
      end
      if (do_invalid) begin
        err_invalid <= 1'b1;
      end
      if (do_retry && (retry_cnt != 2'd3)) begin
        retry_cnt <= retry_cnt + 2'd1;
      end
      if (do_timeout) begin
        err_timeout <= 1'b1;
      end
      if (do_finish) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: doc/digit_requester.md
DIGIT_REQUESTER -- requirements
Module: digit_requester

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5_000_000, is the number of clk cycles to wait for a response byte after each request is sent.
REQ-002 Parameter MAX_RETRIES, default 2, is the number of re-sends allowed after the first timeout (0 = no retry).
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle pulse that requests one digit read.
REQ-006 tx_data  output  8  byte to the UART transmitter.
REQ-007 tx_send  output  1  single-cycle pulse that starts a UART transmission.
REQ-008 tx_busy  input  1  UART transmitter busy (level).
REQ-009 rx_data  input  8  byte from the UART receiver; valid while rx_ready is high.
REQ-010 rx_ready  input  1  UART receiver data-ready (level; a new byte is indicated by its rising edge).
REQ-011 busy  output  1  high from start acceptance until done.
REQ-012 done  output  1  single-cycle pulse when a transaction finishes, whether OK or failed.
REQ-013 digit  output  4  last valid predicted digit (0-9), held between transactions.
REQ-014 err_timeout  output  1  last transaction exhausted all retries; held.
REQ-015 err_invalid  output  1  last transaction received a non-digit byte; held.
REQ-016 retry_cnt  output  2  number of retries used by the last or current transaction; saturates at 3.

Function
REQ-017 States SHALL be IDLE, SEND, WAIT_RESP and FINISH; any other encoding SHALL go to IDLE on the next cycle.
REQ-018 IDLE: start=1 SHALL, on the next cycle, set busy=1, clear err_timeout, err_invalid and retry_cnt, and enter SEND; start outside IDLE SHALL be ignored.
REQ-019 SEND: when tx_busy=0, the block SHALL drive tx_data=0xCC, pulse tx_send for exactly one cycle, clear the timeout counter and enter WAIT_RESP; when tx_busy=1 it SHALL wait in SEND indefinitely.
REQ-020 rx_ready_prev SHALL be registered every cycle in all states; a byte event SHALL be rx_ready=1 with rx_ready_prev=0.
REQ-021 WAIT_RESP, byte event with rx_data[7:4]=0 and rx_data[3:0]<=9: digit SHALL be set to rx_data[3:0], and the block SHALL enter FINISH.
REQ-022 WAIT_RESP, byte event with any other value: digit SHALL be unchanged, err_invalid SHALL be set to 1, and the block SHALL enter FINISH; no retry.
REQ-023 WAIT_RESP with no byte event: the counter SHALL increment each cycle; on the cycle the counter equals TIMEOUT_CYCLES-1:
  - if retry_cnt < MAX_RETRIES: increment retry_cnt and return to SEND;
  - otherwise: set err_timeout=1 and enter FINISH.
REQ-024 A byte event on the same cycle as the timeout condition SHALL take priority (it is treated as a response).
REQ-025 Byte events in IDLE, SEND or FINISH SHALL be ignored and discarded; they SHALL NOT change digit or the error flags.
REQ-026 FINISH SHALL pulse done=1 for one cycle, drop busy, and return to IDLE; start may be accepted on the next cycle.
REQ-027 Minimum latency: start at cycle N; tx_send at N+2 when tx_busy=0; a response event at cycle M gives done at M+2.
REQ-028 The timeout counter SHALL be $clog2(TIMEOUT_CYCLES) bits wide, SHALL never wrap, and SHALL be cleared on each SEND exit.

Reset
REQ-029 rst SHALL force: state=IDLE, tx_data=0, tx_send=0, busy=0, done=0, digit=0, err_timeout=0, err_invalid=0, retry_cnt=0, counter=0, rx_ready_prev=0.
REQ-030 rst asserted mid-transaction SHALL abort it without a done pulse; a response arriving after reset SHALL be ignored per REQ-025.

Structure
REQ-031 The shared UART protocol package SHALL hold REQUEST_BYTE (0xCC), the digit-valid range limit (9) and the state encoding; the responder SHALL use the same constant.
REQ-032 The block SHALL be a single module with no sub-modules; it SHALL connect to the existing UART TX/RX instances.

Verification (bench: TIMEOUT_CYCLES=100, MAX_RETRIES=2, loopback to a responder model)
REQ-033 start, responder returns 0x07 after 40 cycles -> one tx_send with tx_data=0xCC; done pulse; digit=7; both errors 0; retry_cnt=0.
REQ-034 start, no response -> exactly 3 tx_send pulses ~100 cycles apart; done; err_timeout=1; retry_cnt=2; digit unchanged.
REQ-035 First request dropped, response 0x03 arrives 20 cycles after the second send -> done; digit=3; retry_cnt=1; err_timeout=0.
REQ-036 Response 0x1A, then a separate run with 0x0C -> err_invalid=1 in each case; digit keeps its prior value; only 1 send each.
REQ-037 tx_busy held high 500 cycles after start -> no tx_send until tx_busy falls, and no timeout; spurious rx byte 0x05 in IDLE -> digit unchanged.
REQ-038 rst pulsed in WAIT_RESP, then response 0x04 arrives -> no done, digit=0; a subsequent start completes normally.
